// File: rtl/sr_load_if.sv
// Load-request handshake between a requester and sr_load_ctrl.
interface sr_load_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             req_force;

  modport master (output req_valid, output req_data, output req_force, input req_ready);
  modport slave  (input req_valid, input req_data, input req_force, output req_ready);
endinterface

// File: rtl/sr_load_ctrl.sv
// Drives S/R inputs of a bank of SR flip-flops so their Q matches a requested pattern,
// tracking the bank state in q_shadow and never asserting S and R on the same bit.
module sr_load_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  sr_load_if.slave         req,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q_shadow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] tgt;
  logic             ready;
  logic [WIDTH-1:0] set_mask_c;
  logic [WIDTH-1:0] clr_mask_c;

  // Delta masks against the tracked bank state, only consumed on the handshake edge
  assign set_mask_c    = req.req_data & ~q_shadow;
  assign clr_mask_c    = ~req.req_data & q_shadow;
  assign req.req_ready = ready;

  // Phase sequencer; s/r change only together with the state, so S and R never overlap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tgt      <= '0;
      s        <= '0;
      r        <= '0;
      q_shadow <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid && ready) begin
            tgt   <= req.req_data;
            busy  <= 1'b1;
            ready <= 1'b0;
            cnt   <= CNT_LOAD;
            if (req.req_force) begin
              state <= CLEAR;
              s     <= '0;
              r     <= '1;
            end else if (|(set_mask_c | clr_mask_c)) begin
              state <= DRIVE;
              s     <= set_mask_c;
              r     <= clr_mask_c;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (cnt == '0) begin
            state    <= DRIVE;
            q_shadow <= '0;
            s        <= tgt;
            r        <= '0;
            cnt      <= CNT_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state    <= DONE;
            q_shadow <= tgt;
            s        <= '0;
            r        <= '0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_load_ctrl.sv
// Bench for sr_load_ctrl: SETTLE=1 and SETTLE=3 instances checked against a per-cycle plan model.
module tb_sr_load_ctrl;

  logic clk;
  logic reset;
  logic [7:0] s1, r1, q1, s3, r3, q3;
  logic busy1, done1, busy3, done3;

  int checks = 0;
  int errors = 0;

  sr_load_if #(.WIDTH(8)) if1 ();
  sr_load_if #(.WIDTH(8)) if3 ();

  sr_load_ctrl #(.WIDTH(8), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .req(if1),
    .s(s1), .r(r1), .q_shadow(q1), .busy(busy1), .done(done1)
  );

  sr_load_ctrl #(.WIDTH(8), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .req(if3),
    .s(s3), .r(r3), .q_shadow(q3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for each cycle following a handshake, built from the load rules
  typedef struct packed {
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t       plan [2][16];
  int         plen [2];
  int         ppos [2];
  logic [7:0] q_m  [2];

  task automatic accept(input int k, input logic [7:0] tgt, input logic frc);
    int n;
    int st;
    logic [7:0] q0, sm, cm;
    n  = 0;
    st = (k == 0) ? 1 : 3;
    q0 = q_m[k];
    sm = tgt & ~q0;
    cm = ~tgt & q0;
    if (frc) begin
      for (int i = 0; i < st; i++) begin
        plan[k][n] = '{s: 8'h00, r: 8'hFF, q: q0, busy: 1'b1, done: 1'b0, ready: 1'b0}; n++;
      end
      for (int i = 0; i < st; i++) begin
        plan[k][n] = '{s: tgt, r: 8'h00, q: 8'h00, busy: 1'b1, done: 1'b0, ready: 1'b0}; n++;
      end
    end else if ((sm | cm) != 8'h00) begin
      for (int i = 0; i < st; i++) begin
        plan[k][n] = '{s: sm, r: cm, q: q0, busy: 1'b1, done: 1'b0, ready: 1'b0}; n++;
      end
    end
    plan[k][n] = '{s: 8'h00, r: 8'h00, q: tgt, busy: 1'b1, done: 1'b1, ready: 1'b0}; n++;
    plen[k] = n;
    ppos[k] = 0;
    q_m[k]  = tgt;
  endtask

  // Model advance: one plan entry per clock, accept only when the plan is exhausted
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        plen[k] = 0; ppos[k] = 0; q_m[k] = 8'h00;
      end else if (ppos[k] < plen[k]) begin
        ppos[k]++;
      end else if ((k == 0) ? if1.req_valid : if3.req_valid) begin
        if (k == 0) accept(0, if1.req_data, if1.req_force);
        else        accept(1, if3.req_data, if3.req_force);
      end
    end
  end

  exp_t       e_c;
  logic [7:0] as_c, ar_c, aq_c;
  logic       ab_c, ad_c, ay_c;

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset)
        e_c = '{s: 8'h00, r: 8'h00, q: 8'h00, busy: 1'b0, done: 1'b0, ready: 1'b1};
      else if (ppos[k] < plen[k])
        e_c = plan[k][ppos[k]];
      else
        e_c = '{s: 8'h00, r: 8'h00, q: q_m[k], busy: 1'b0, done: 1'b0, ready: 1'b1};
      if (k == 0) begin
        as_c = s1; ar_c = r1; aq_c = q1; ab_c = busy1; ad_c = done1; ay_c = if1.req_ready;
      end else begin
        as_c = s3; ar_c = r3; aq_c = q3; ab_c = busy3; ad_c = done3; ay_c = if3.req_ready;
      end
      chk($sformatf("model%0d.s", k), as_c, e_c.s);
      chk($sformatf("model%0d.r", k), ar_c, e_c.r);
      chk($sformatf("model%0d.q_shadow", k), aq_c, e_c.q);
      chk($sformatf("model%0d.busy", k), ab_c, e_c.busy);
      chk($sformatf("model%0d.done", k), ad_c, e_c.done);
      chk($sformatf("model%0d.req_ready", k), ay_c, e_c.ready);
      chk($sformatf("model%0d.s_and_r", k), as_c & ar_c, 8'h00);
    end
  end

  // Present one request for one edge; returns at the negedge of the first cycle after it
  task automatic send(input int k, input logic [7:0] d, input logic f);
    if (k == 0) begin if1.req_valid = 1'b1; if1.req_data = d; if1.req_force = f; end
    else        begin if3.req_valid = 1'b1; if3.req_data = d; if3.req_force = f; end
    @(negedge clk);
    if1.req_valid = 1'b0;
    if3.req_valid = 1'b0;
  endtask

  int dn;

  initial begin
    reset = 1'b0;
    if1.req_valid = 1'b0; if1.req_data = 8'h00; if1.req_force = 1'b0;
    if3.req_valid = 1'b0; if3.req_data = 8'h00; if3.req_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.ready1", if1.req_ready, 1'b1);
    chk("reset.q1", q1, 8'h00);
    chk("reset.busy3", busy3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("release.ready1", if1.req_ready, 1'b1);

    // SETTLE=1 delta loads
    send(0, 8'hA5, 1'b0);
    chk("a5.s", s1, 8'hA5); chk("a5.r", r1, 8'h00); chk("a5.busy", busy1, 1'b1);
    @(negedge clk);
    chk("a5.done", done1, 1'b1); chk("a5.q", q1, 8'hA5); chk("a5.s_off", s1, 8'h00);
    @(negedge clk);
    chk("a5.ready", if1.req_ready, 1'b1);

    send(0, 8'h0F, 1'b0);
    chk("0f.s", s1, 8'h0A); chk("0f.r", r1, 8'hA0);
    @(negedge clk);
    chk("0f.done", done1, 1'b1); chk("0f.q", q1, 8'h0F);
    @(negedge clk);

    send(0, 8'h0F, 1'b0);
    chk("same.done", done1, 1'b1); chk("same.s", s1, 8'h00); chk("same.r", r1, 8'h00);
    @(negedge clk);
    chk("same.ready", if1.req_ready, 1'b1);

    // SETTLE=3: preload all ones, then force 3C
    send(1, 8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    chk("ff.q", q3, 8'hFF); chk("ff.ready", if3.req_ready, 1'b1);

    send(1, 8'h3C, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      if (i <= 3) begin
        chk("force.r_phase", r3, 8'hFF); chk("force.s_in_clear", s3, 8'h00);
      end else if (i <= 6) begin
        chk("force.s_phase", s3, 8'h3C); chk("force.r_in_drive", r3, 8'h00);
      end
      chk("force.done", done3, (i == 7) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    chk("force.ready", if3.req_ready, 1'b1); chk("force.q", q3, 8'h3C);

    send(1, 8'h00, 1'b1);
    repeat (6) @(negedge clk);
    chk("force0.done", done3, 1'b1); chk("force0.q", q3, 8'h00);
    @(negedge clk);

    // Valid held for 10 cycles with changing data
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if3.req_valid = 1'b1;
      if3.req_data  = 8'(8'h11 * (i + 1));
      if3.req_force = 1'b0;
      @(negedge clk);
      if (done3) dn++;
    end
    if3.req_valid = 1'b0;
    repeat (8) begin @(negedge clk); if (done3) dn++; end
    chk("hold.done_count", dn, 2);
    chk("hold.q", q3, 8'h66);

    // Asynchronous reset in the second DRIVE cycle
    send(1, 8'h5A, 1'b0);
    @(negedge clk);
    chk("abort.s_before", s3, 8'h18); chk("abort.r_before", r3, 8'h24);
    #3 reset = 1'b0;
    #1;
    chk("abort.s", s3, 8'h00); chk("abort.r", r3, 8'h00);
    chk("abort.q", q3, 8'h00); chk("abort.busy", busy3, 1'b0);
    chk("abort.q1", q1, 8'h00);
    dn = 0;
    repeat (2) begin @(negedge clk); if (done3) dn++; end
    reset = 1'b1;
    @(negedge clk);
    chk("abort.ready", if3.req_ready, 1'b1);
    repeat (3) begin @(negedge clk); if (done3) dn++; end
    chk("abort.no_done", dn, 0);

    send(1, 8'h81, 1'b0);
    chk("post.s", s3, 8'h81); chk("post.r", r3, 8'h00);
    repeat (4) @(negedge clk);

    send(0, 8'h3C, 1'b1);
    chk("f1.r", r1, 8'hFF); chk("f1.s", s1, 8'h00);
    @(negedge clk);
    chk("f1.s_drive", s1, 8'h3C); chk("f1.r_drive", r1, 8'h00);
    @(negedge clk);
    chk("f1.done", done1, 1'b1); chk("f1.q", q1, 8'h3C);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_load_ctrl.md
SR_LOAD_CTRL -- requirements
Module: sr_load_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of downstream SR flip-flops driven.
REQ-002 SHALL have parameter SETTLE, default 1, legal range 1..15: cycles each S/R drive phase is held.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  load request valid.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_data  input  WIDTH  target Q pattern for the flip-flop bank.
REQ-008 SHALL have port req_force  input  1  1 = clear all bits, then set; 0 = drive only changed bits.
REQ-009 SHALL have port s  output  WIDTH  set drive, bit i goes to S of flip-flop i.
REQ-010 SHALL have port r  output  WIDTH  reset drive, bit i goes to R of flip-flop i.
REQ-011 SHALL have port q_shadow  output  WIDTH  tracked Q state of the flip-flop bank.
REQ-012 SHALL have port busy  output  1  request in progress (state not IDLE).
REQ-013 SHALL have port done  output  1  one-cycle pulse when a load completes.

Function
REQ-014 SHALL implement states IDLE, CLEAR, DRIVE and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; a handshake occurs on the rising edge where req_valid=1 and req_ready=1.
REQ-016 On handshake SHALL capture tgt=req_data and frc=req_force; req_data is ignored at all other times.
REQ-017 Delta mode (frc=0): set_mask = tgt & ~q_shadow and clr_mask = ~tgt & q_shadow SHALL be computed from the captured values.
REQ-018 Delta mode with set_mask=clr_mask=0: IDLE -> DONE on the handshake edge; no S/R asserted.
REQ-019 Delta mode, otherwise: IDLE -> DRIVE with s=set_mask and r=clr_mask, held for exactly SETTLE cycles.
REQ-020 Force mode (frc=1): IDLE -> CLEAR with r=all ones and s=0 for SETTLE cycles, then CLEAR -> DRIVE with s=tgt and r=0 for SETTLE cycles.
REQ-021 Force mode SHALL still enter DRIVE when tgt=0, with s=0 for SETTLE cycles.
REQ-022 At the end of CLEAR, q_shadow SHALL become 0.
REQ-023 At the end of DRIVE, q_shadow SHALL become tgt and the state SHALL go DRIVE -> DONE.
REQ-024 DONE SHALL last 1 cycle with done=1, s=0 and r=0, then go to IDLE.
REQ-025 s and r SHALL be registered outputs, and s[i]&r[i] SHALL never be 1 in any cycle, including state transitions.
REQ-026 s and r SHALL be 0 in IDLE and DONE.
REQ-027 A 4-bit down-counter SHALL time each phase: load SETTLE-1 on phase entry and leave the phase when it reads 0.
REQ-028 Delta-mode latency: handshake at edge T -> s/r active cycles T+1..T+SETTLE -> done=1 in cycle T+SETTLE+1 -> req_ready=1 in cycle T+SETTLE+2.
REQ-029 Force-mode latency SHALL be SETTLE cycles longer than delta mode.
REQ-030 req_valid held high during busy SHALL have no effect; the request is accepted on the first IDLE cycle.
REQ-031 busy SHALL be 1 in CLEAR, DRIVE and DONE.

Reset
REQ-032 reset=0 SHALL asynchronously force state=IDLE, s=0, r=0, q_shadow=0, done=0, busy=0 and counter=0.
REQ-033 q_shadow reset value 0 SHALL match the reset value of the downstream flip-flops.
REQ-034 Reset asserted mid-CLEAR or mid-DRIVE SHALL abort the request with no done pulse; the first request after reset is computed against q_shadow=0.
REQ-035 Reset release SHALL take effect at the next rising clk edge; req_ready=1 in the first cycle after release.

Verification
REQ-036 WIDTH=8, SETTLE=1, delta, req_data=8'hA5 from reset -> s=8'hA5, r=0 for 1 cycle; done the next cycle; q_shadow=8'hA5.
REQ-037 Then delta req_data=8'h0F -> s=8'h0A, r=8'hA0 for 1 cycle; q_shadow=8'h0F; s&r=0 in every cycle.
REQ-038 Delta req_data equal to q_shadow -> s=r=0 throughout; done one cycle after the handshake.
REQ-039 SETTLE=3, force, req_data=8'h3C with q_shadow=8'hFF -> r=8'hFF for 3 cycles, then s=8'h3C for 3 cycles, then done; total 7 cycles from the handshake.
REQ-040 req_valid held high for 10 cycles with changing req_data -> only the first value and the value presented on the next IDLE cycle are accepted; exactly two done pulses.
REQ-041 reset pulled low during the 2nd DRIVE cycle (SETTLE=3) -> s, r, q_shadow and busy become 0 immediately with no clk edge; no done pulse; req_ready=1 after release.
